// File: rtl/wb_scoreboard_pkg.sv
// Shared constants and helpers for the writeback scoreboard.
package wb_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NLANE      = 3;
  localparam int NREG       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Number of valid lanes (out of three) whose destination equals r.
  function automatic logic [1:0] lane_hits(
    input logic [2:0]            v,
    input logic [REG_ADDR_W-1:0] rd1,
    input logic [REG_ADDR_W-1:0] rd2,
    input logic [REG_ADDR_W-1:0] rd3,
    input logic [REG_ADDR_W-1:0] r
  );
    logic h1, h2, h3;
    h1 = v[0] && (rd1 == r);
    h2 = v[1] && (rd2 == r);
    h3 = v[2] && (rd3 == r);
    return {1'b0, h1} + {1'b0, h2} + {1'b0, h3};
  endfunction

endpackage

// File: rtl/wb_scoreboard_sb_cnt.sv
// Pending-write counter for one architectural register.
module sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] add,
  input  logic [CNT_W-1:0] sub,
  input  logic             stall,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             underflow
);

  logic [CNT_W-1:0] add_eff;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   diff;

  // A stalled group reserves nothing; retirements always apply.
  always_comb begin
    add_eff   = stall ? '0 : add;
    sum       = {1'b0, cnt} + {1'b0, add_eff};
    underflow = ({1'b0, sub} > sum);
    diff      = sum - {1'b0, sub};
  end

  // Count register; an underflow clamps to zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (underflow)
      cnt <= '0;
    else
      cnt <= diff[CNT_W-1:0];
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback arbiter and destination scoreboard for the three-lane datapath.
import wb_scoreboard_pkg::*;

module wb_scoreboard #(
  parameter int NLANE = 3,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsv_valid1,
  input  logic                  rsv_valid2,
  input  logic                  rsv_valid3,
  input  logic [REG_ADDR_W-1:0] rsv_rd1,
  input  logic [REG_ADDR_W-1:0] rsv_rd2,
  input  logic [REG_ADDR_W-1:0] rsv_rd3,
  output logic                  rsv_stall,
  input  logic                  res_valid1,
  input  logic                  res_valid2,
  input  logic                  res_valid3,
  input  logic [REG_ADDR_W-1:0] res_rd1,
  input  logic [REG_ADDR_W-1:0] res_rd2,
  input  logic [REG_ADDR_W-1:0] res_rd3,
  input  logic [DATA_W-1:0]     res_data1,
  input  logic [DATA_W-1:0]     res_data2,
  input  logic [DATA_W-1:0]     res_data3,
  output logic                  we1,
  output logic                  we2,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] rw1,
  output logic [REG_ADDR_W-1:0] rw2,
  output logic [REG_ADDR_W-1:0] rw3,
  output logic [DATA_W-1:0]     inW1,
  output logic [DATA_W-1:0]     inW2,
  output logic [DATA_W-1:0]     inW3,
  output logic [NREG-1:0]       busy,
  output logic                  sb_err
);

  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'((1 << CNT_W) - 1);

  logic [2:0]       rsv_v;
  logic [2:0]       res_v;
  logic [NREG-1:1]  ovf;
  logic [NREG-1:1]  uf;
  logic [NREG-1:1]  busy_r;
  logic [NLANE-1:0] win;

  assign rsv_v = {rsv_valid3, rsv_valid2, rsv_valid1};
  assign res_v = {res_valid3, res_valid2, res_valid1};

  // Register 0 is excluded by starting at 1: it is never counted or reserved.
  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic [CNT_W-1:0] add_r;
    logic [CNT_W-1:0] sub_r;
    logic [CNT_W-1:0] cnt_r;

    // Match decode of reservations and retirements against this register.
    always_comb begin
      add_r  = CNT_W'(lane_hits(rsv_v, rsv_rd1, rsv_rd2, rsv_rd3, REG_ADDR_W'(r)));
      sub_r  = CNT_W'(lane_hits(res_v, res_rd1, res_rd2, res_rd3, REG_ADDR_W'(r)));
      ovf[r] = ({1'b0, cnt_r} + {1'b0, add_r}) > CNT_MAX;
    end

    sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .add       (add_r),
      .sub       (sub_r),
      .stall     (rsv_stall),
      .cnt       (cnt_r),
      .busy      (busy_r[r]),
      .underflow (uf[r])
    );
  end

  // Any register that would exceed its max count blocks the whole group;
  // same-cycle retirements are deliberately not credited here.
  assign rsv_stall = |ovf;
  assign busy      = {busy_r, 1'b0};

  // Only the youngest writer of a destination survives; older duplicates drop.
  always_comb begin
    win    = '0;
    win[0] = res_valid1 && (res_rd1 != REG_ZERO)
             && !(res_valid2 && (res_rd2 == res_rd1))
             && !(res_valid3 && (res_rd3 == res_rd1));
    win[1] = res_valid2 && (res_rd2 != REG_ZERO)
             && !(res_valid3 && (res_rd3 == res_rd2));
    win[2] = res_valid3 && (res_rd3 != REG_ZERO);
  end

  // Register-file write ports; address/data hold when a lane does not write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we1  <= 1'b0;
      we2  <= 1'b0;
      we3  <= 1'b0;
      rw1  <= '0;
      rw2  <= '0;
      rw3  <= '0;
      inW1 <= '0;
      inW2 <= '0;
      inW3 <= '0;
    end else begin
      we1 <= win[0];
      we2 <= win[1];
      we3 <= win[2];
      if (win[0]) begin
        rw1  <= res_rd1;
        inW1 <= res_data1;
      end
      if (win[1]) begin
        rw2  <= res_rd2;
        inW2 <= res_data2;
      end
      if (win[2]) begin
        rw3  <= res_rd3;
        inW3 <= res_data3;
      end
    end
  end

  // Sticky error: a result retired a register with nothing pending.
  always_ff @(posedge clk) begin
    if (rst)
      sb_err <= 1'b0;
    else if (|uf)
      sb_err <= 1'b1;
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard-style bench for wb_scoreboard: writes are checked by a monitor
// against a queue of hand-computed expected port states.
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        rsv_valid1, rsv_valid2, rsv_valid3;
  logic [4:0]  rsv_rd1, rsv_rd2, rsv_rd3;
  logic        rsv_stall;
  logic        res_valid1, res_valid2, res_valid3;
  logic [4:0]  res_rd1, res_rd2, res_rd3;
  logic [31:0] res_data1, res_data2, res_data3;
  logic        we1, we2, we3;
  logic [4:0]  rw1, rw2, rw3;
  logic [31:0] inW1, inW2, inW3;
  logic [31:0] busy;
  logic        sb_err;

  typedef struct {
    logic [2:0]  we;
    logic [4:0]  rw1, rw2, rw3;
    logic [31:0] d1, d2, d3;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  wb_scoreboard dut (
    .clk(clk), .rst(rst),
    .rsv_valid1(rsv_valid1), .rsv_valid2(rsv_valid2), .rsv_valid3(rsv_valid3),
    .rsv_rd1(rsv_rd1), .rsv_rd2(rsv_rd2), .rsv_rd3(rsv_rd3),
    .rsv_stall(rsv_stall),
    .res_valid1(res_valid1), .res_valid2(res_valid2), .res_valid3(res_valid3),
    .res_rd1(res_rd1), .res_rd2(res_rd2), .res_rd3(res_rd3),
    .res_data1(res_data1), .res_data2(res_data2), .res_data3(res_data3),
    .we1(we1), .we2(we2), .we3(we3),
    .rw1(rw1), .rw2(rw2), .rw3(rw3),
    .inW1(inW1), .inW2(inW2), .inW3(inW3),
    .busy(busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {rsv_valid1, rsv_valid2, rsv_valid3} = '0;
    {rsv_rd1, rsv_rd2, rsv_rd3}          = '0;
    {res_valid1, res_valid2, res_valid3} = '0;
    {res_rd1, res_rd2, res_rd3}          = '0;
    {res_data1, res_data2, res_data3}    = '0;
  endtask

  task automatic push_exp(input logic [2:0] we,
                          input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    exp_t e;
    e.we = we; e.rw1 = a1; e.rw2 = a2; e.rw3 = a3;
    e.d1 = d1; e.d2 = d2; e.d3 = d3;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle that presents a write is matched to the next expectation.
  always @(negedge clk) begin
    if (we1 === 1'b1 || we2 === 1'b1 || we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: got we=%b%b%b expected no write at %0t", we3, we2, we1, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("we_vec", {29'd0, we3, we2, we1}, {29'd0, e.we});
        check("rw1", {27'd0, rw1}, {27'd0, e.rw1});
        check("rw2", {27'd0, rw2}, {27'd0, e.rw2});
        check("rw3", {27'd0, rw3}, {27'd0, e.rw3});
        check("inW1", inW1, e.d1);
        check("inW2", inW2, e.d2);
        check("inW3", inW3, e.d3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_busy", busy, 32'd0);
    check("rst_we", {29'd0, we3, we2, we1}, 32'd0);
    check("rst_rw", {17'd0, rw3, rw2, rw1}, 32'd0);
    check("rst_inW1", inW1, 32'd0);
    check("rst_inW3", inW3, 32'd0);
    check("rst_sb_err", {31'd0, sb_err}, 32'd0);
    check("rst_stall", {31'd0, rsv_stall}, 32'd0);

    // Single flow on r5
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd5;
    step();
    clear_inputs();
    check("single_busy5_set", {31'd0, busy[5]}, 32'd1);
    res_valid1 = 1'b1; res_rd1 = 5'd5; res_data1 = 32'hDEADBEEF;
    push_exp(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0);
    step();
    clear_inputs();
    check("single_busy5_clr", {31'd0, busy[5]}, 32'd0);

    // WAW group on r7
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd7;
    rsv_valid2 = 1'b1; rsv_rd2 = 5'd7;
    rsv_valid3 = 1'b1; rsv_rd3 = 5'd7;
    check("waw_no_stall", {31'd0, rsv_stall}, 32'd0);
    step();
    clear_inputs();
    check("waw_busy7_set", {31'd0, busy[7]}, 32'd1);
    res_valid1 = 1'b1; res_rd1 = 5'd7; res_data1 = 32'd1;
    res_valid2 = 1'b1; res_rd2 = 5'd7; res_data2 = 32'd2;
    res_valid3 = 1'b1; res_rd3 = 5'd7; res_data3 = 32'd3;
    push_exp(3'b100, 5'd5, 5'd0, 5'd7, 32'hDEADBEEF, 32'd0, 32'd3);
    step();
    clear_inputs();
    check("waw_busy7_clr", {31'd0, busy[7]}, 32'd0);
    check("waw_no_err", {31'd0, sb_err}, 32'd0);

    // Saturation on r9
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd9;
    rsv_valid2 = 1'b1; rsv_rd2 = 5'd9;
    rsv_valid3 = 1'b1; rsv_rd3 = 5'd9;
    step();
    clear_inputs();
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd9;
    rsv_valid2 = 1'b1; rsv_rd2 = 5'd4;
    #1;
    check("sat_stall", {31'd0, rsv_stall}, 32'd1);
    step();
    clear_inputs();
    check("sat_busy4_not_counted", {31'd0, busy[4]}, 32'd0);
    check("sat_busy9", {31'd0, busy[9]}, 32'd1);
    // cnt9 still 3: reserve+retire stalls, retirement still applies
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd9;
    res_valid1 = 1'b1; res_rd1 = 5'd9; res_data1 = 32'h99;
    #1;
    check("sat_stall_with_retire", {31'd0, rsv_stall}, 32'd1);
    push_exp(3'b001, 5'd9, 5'd0, 5'd7, 32'h99, 32'd0, 32'd3);
    step();
    res_valid1 = 1'b0; res_rd1 = 5'd0; res_data1 = 32'd0;
    #1;
    check("sat_stall_dropped", {31'd0, rsv_stall}, 32'd0);
    step();
    clear_inputs();
    // cnt9 back to 3; retire all three in one group
    res_valid1 = 1'b1; res_rd1 = 5'd9; res_data1 = 32'hA;
    res_valid2 = 1'b1; res_rd2 = 5'd9; res_data2 = 32'hB;
    res_valid3 = 1'b1; res_rd3 = 5'd9; res_data3 = 32'hC;
    push_exp(3'b100, 5'd9, 5'd0, 5'd9, 32'h99, 32'd0, 32'hC);
    step();
    clear_inputs();
    check("sat_busy9_clr", {31'd0, busy[9]}, 32'd0);
    check("sat_no_err", {31'd0, sb_err}, 32'd0);

    // Net change: cnt5=1, +1 reserve and -1 retire keeps it at 1
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd5;
    step();
    clear_inputs();
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd5;
    res_valid1 = 1'b1; res_rd1 = 5'd5; res_data1 = 32'h51;
    #1;
    check("net_no_stall", {31'd0, rsv_stall}, 32'd0);
    push_exp(3'b001, 5'd5, 5'd0, 5'd9, 32'h51, 32'd0, 32'hC);
    step();
    clear_inputs();
    check("net_busy5_held", {31'd0, busy[5]}, 32'd1);
    res_valid2 = 1'b1; res_rd2 = 5'd5; res_data2 = 32'h52;
    push_exp(3'b010, 5'd5, 5'd5, 5'd9, 32'h51, 32'h52, 32'hC);
    step();
    clear_inputs();
    check("net_busy5_clr", {31'd0, busy[5]}, 32'd0);

    // Register zero is never counted or written
    rsv_valid2 = 1'b1; rsv_rd2 = 5'd0;
    res_valid2 = 1'b1; res_rd2 = 5'd0; res_data2 = 32'h1234;
    #1;
    check("r0_no_stall", {31'd0, rsv_stall}, 32'd0);
    step();
    clear_inputs();
    check("r0_busy_all", busy, 32'd0);
    check("r0_no_err", {31'd0, sb_err}, 32'd0);

    // Underflow: retire r12 with nothing pending
    res_valid1 = 1'b1; res_rd1 = 5'd12; res_data1 = 32'h55;
    push_exp(3'b001, 5'd12, 5'd5, 5'd9, 32'h55, 32'h52, 32'hC);
    step();
    clear_inputs();
    check("uf_err_set", {31'd0, sb_err}, 32'd1);
    check("uf_busy12", {31'd0, busy[12]}, 32'd0);
    step();
    check("uf_err_sticky", {31'd0, sb_err}, 32'd1);

    // Mid-operation reset with r3 reserved and a result in flight
    rsv_valid1 = 1'b1; rsv_rd1 = 5'd3;
    step();
    clear_inputs();
    check("mid_busy3_set", {31'd0, busy[3]}, 32'd1);
    res_valid2 = 1'b1; res_rd2 = 5'd3; res_data2 = 32'h77;
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    check("mid_busy_clr", busy, 32'd0);
    check("mid_err_clr", {31'd0, sb_err}, 32'd0);
    check("mid_we_clr", {29'd0, we3, we2, we1}, 32'd0);
    check("mid_rw_clr", {17'd0, rw3, rw2, rw1}, 32'd0);
    check("mid_inW_clr", inW1 | inW2 | inW3, 32'd0);

    step();
    step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
